// File: rtl/prime_scan_if.sv
// Bus bundle for prime_scan: scan control, checker handshake and prime FIFO read side.
interface prime_scan_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] num;
  logic             res;
  logic [WIDTH-1:0] prime_out;
  logic             prime_valid;
  logic             prime_ready;
  logic [WIDTH:0]   prime_count;
  logic             busy;
  logic             done;

  // Environment side: issues start, answers the checker, consumes primes.
  modport master (
    output start, res, prime_ready,
    input  num, prime_out, prime_valid, prime_count, busy, done
  );

  // Scanner side.
  modport slave (
    input  start, res, prime_ready,
    output num, prime_out, prime_valid, prime_count, busy, done
  );
endinterface

// File: rtl/prime_scan.sv
// Prime scanner: walks cnt over 0..2^WIDTH-1, asks an external combinational
// checker about each value and queues the primes in a small FIFO. The scan
// stalls on a prime while the FIFO is full.
module prime_scan #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  prime_scan_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH:0]   pc;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      occ;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic last;

  // Full is taken from the current occupancy, so a pop in the same cycle
  // does not let a stalled prime in until the following cycle.
  assign full  = (occ == (AW+1)'(DEPTH));
  assign empty = (occ == '0);
  assign push  = (state == SCAN) && bus.res && !full;
  assign pop   = !empty && bus.prime_ready;
  assign last  = (cnt == '1);

  // Scan FSM with registered status outputs and the candidate counter.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      pc     <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state  <= SCAN;
            cnt    <= '0;
            pc     <= '0;
            busy_q <= 1'b1;
            done_q <= 1'b0;
          end
        end
        SCAN: begin
          // A prime that cannot be queued holds cnt until a slot frees.
          if (!(bus.res && full)) begin
            if (last) begin
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          if (push && (pc != '1)) pc <= pc + 1'b1;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // FIFO storage write port.
  // NOTE: the storage array is deliberately not reset; emptiness is tracked
  // by occ, and prime_out is masked while empty so stale data never shows.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cnt;
  end

  assign bus.num         = cnt;
  assign bus.prime_out   = empty ? '0 : mem[rd_ptr];
  assign bus.prime_valid = !empty;
  assign bus.prime_count = pc;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
endmodule

// File: tb/tb_prime_scan.sv
// Self-checking bench for prime_scan: golden checker drives res, a queue
// scoreboard holds the expected pop order and a monitor compares every pop.
module tb_prime_scan;
  localparam int WIDTH = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic force_all = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [WIDTH-1:0] exp_q [$];

  prime_scan_if #(.WIDTH(WIDTH)) bus ();

  prime_scan #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic is_prime(input logic [WIDTH-1:0] v);
    int x;
    x = int'(v);
    if (x < 2) return 1'b0;
    for (int d = 2; d < x; d++) if (x % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  assign bus.res = force_all | is_prime(bus.num);

  // Monitor: every accepted pop is checked against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && bus.prime_valid && bus.prime_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected got %0d want none", bus.prime_out);
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        if (bus.prime_out !== e) begin
          errors++;
          $display("FAIL pop_order got %0d want %0d", bus.prime_out, e);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_primes();
    for (int v = 0; v < (1 << WIDTH); v++)
      if (is_prime(WIDTH'(v))) exp_q.push_back(WIDTH'(v));
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    while (!bus.done && n < limit) begin
      cyc(1);
      n++;
    end
    if (!bus.done) begin
      checks++;
      errors++;
      $display("FAIL wait_done_timeout got %0d cycles want done", n);
    end
  endtask

  task automatic wait_num(input logic [WIDTH-1:0] v, input int limit);
    int n = 0;
    while (bus.num !== v && n < limit) begin
      cyc(1);
      n++;
    end
    if (bus.num !== v) begin
      checks++;
      errors++;
      $display("FAIL wait_num_timeout got %0d want %0d", bus.num, v);
    end
  endtask

  task automatic drain();
    int n = 0;
    bus.prime_ready = 1'b1;
    while ((exp_q.size() != 0 || bus.prime_valid) && n < 100) begin
      cyc(1);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || bus.prime_valid) begin
      errors++;
      $display("FAIL drain got %0d left want 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b1;
    cyc(2);
    bus.start = 1'b0;
    rst = 1'b0;
    checks++;
    if (bus.num !== '0 || bus.prime_valid !== 1'b0 || bus.prime_out !== '0) begin
      errors++;
      $display("FAIL reset_data got num=%0d valid=%0b out=%0d want 0 0 0",
               bus.num, bus.prime_valid, bus.prime_out);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.prime_count !== '0) begin
      errors++;
      $display("FAIL reset_status got busy=%0b done=%0b count=%0d want 0 0 0",
               bus.busy, bus.done, bus.prime_count);
    end
  endtask

  task automatic test_free_run();
    int n;
    bus.prime_ready = 1'b1;
    push_primes();
    pulse_start();
    checks++;
    if (bus.busy !== 1'b1 || bus.num !== '0) begin
      errors++;
      $display("FAIL scan_entry got busy=%0b num=%0d want 1 0", bus.busy, bus.num);
    end
    wait_done(100, n);
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL scan_length got %0d want 16", n);
    end
    checks++;
    if (bus.num !== 4'd15 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL done_hold got num=%0d busy=%0b want 15 0", bus.num, bus.busy);
    end
    cyc(2);
    checks++;
    if (bus.prime_count !== 5'd6 || bus.num !== 4'd15) begin
      errors++;
      $display("FAIL free_count got %0d num=%0d want 6 15", bus.prime_count, bus.num);
    end
    drain();
  endtask

  task automatic test_backpressure();
    int n;
    bus.prime_ready = 1'b0;
    push_primes();
    pulse_start();
    wait_num(4'd11, 40);
    cyc(3);
    checks++;
    if (bus.num !== 4'd11 || bus.busy !== 1'b1 || bus.prime_out !== 4'd2) begin
      errors++;
      $display("FAIL stall got num=%0d busy=%0b out=%0d want 11 1 2",
               bus.num, bus.busy, bus.prime_out);
    end
    checks++;
    if (bus.prime_count !== 5'd4) begin
      errors++;
      $display("FAIL stall_count got %0d want 4", bus.prime_count);
    end
    // Single pop while full: 11 must not enter during the pop cycle.
    bus.prime_ready = 1'b1;
    cyc(1);
    bus.prime_ready = 1'b0;
    checks++;
    if (bus.num !== 4'd11 || bus.prime_count !== 5'd4) begin
      errors++;
      $display("FAIL full_pop_same got num=%0d count=%0d want 11 4",
               bus.num, bus.prime_count);
    end
    cyc(1);
    checks++;
    if (bus.num !== 4'd12 || bus.prime_count !== 5'd5) begin
      errors++;
      $display("FAIL full_pop_next got num=%0d count=%0d want 12 5",
               bus.num, bus.prime_count);
    end
    bus.prime_ready = 1'b1;
    wait_done(100, n);
    drain();
    checks++;
    if (bus.prime_count !== 5'd6) begin
      errors++;
      $display("FAIL bp_count got %0d want 6", bus.prime_count);
    end
  endtask

  task automatic test_reset_mid_scan();
    int n;
    bus.prime_ready = 1'b0;
    pulse_start();
    wait_num(4'd6, 40);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.num !== '0 ||
        bus.prime_valid !== 1'b0 || bus.prime_count !== '0) begin
      errors++;
      $display("FAIL mid_reset got busy=%0b done=%0b num=%0d valid=%0b count=%0d want 0 0 0 0 0",
               bus.busy, bus.done, bus.num, bus.prime_valid, bus.prime_count);
    end
    bus.prime_ready = 1'b1;
    push_primes();
    pulse_start();
    checks++;
    if (bus.num !== '0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL rescan_entry got num=%0d busy=%0b want 0 1", bus.num, bus.busy);
    end
    wait_done(100, n);
    drain();
    checks++;
    if (bus.prime_count !== 5'd6) begin
      errors++;
      $display("FAIL rescan_count got %0d want 6", bus.prime_count);
    end
  endtask

  task automatic test_start_ignored();
    int n;
    bus.prime_ready = 1'b1;
    push_primes();
    pulse_start();
    cyc(3);
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    checks++;
    if (bus.num !== 4'd4 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL start_in_scan got num=%0d busy=%0b want 4 1", bus.num, bus.busy);
    end
    wait_done(100, n);
    drain();
  endtask

  task automatic test_restart_keeps_fifo();
    int n;
    bus.prime_ready = 1'b1;
    push_primes();
    pulse_start();
    wait_num(4'd10, 40);
    bus.prime_ready = 1'b0;
    wait_done(100, n);
    checks++;
    if (bus.prime_valid !== 1'b1 || bus.prime_out !== 4'd11) begin
      errors++;
      $display("FAIL leftover got valid=%0b out=%0d want 1 11", bus.prime_valid, bus.prime_out);
    end
    push_primes();
    pulse_start();
    wait_num(4'd5, 40);
    cyc(2);
    checks++;
    if (bus.prime_count !== 5'd2 || bus.prime_out !== 4'd11 || bus.num !== 4'd5) begin
      errors++;
      $display("FAIL restart_keep got count=%0d out=%0d num=%0d want 2 11 5",
               bus.prime_count, bus.prime_out, bus.num);
    end
    bus.prime_ready = 1'b1;
    wait_done(100, n);
    drain();
  endtask

  task automatic test_force_all();
    int n = 0;
    force_all = 1'b1;
    for (int v = 0; v < (1 << WIDTH); v++) exp_q.push_back(WIDTH'(v));
    pulse_start();
    while (!bus.done && n < 300) begin
      bus.prime_ready = 1'($urandom_range(0, 1));
      cyc(1);
      n++;
    end
    bus.prime_ready = 1'b0;
    checks++;
    if (bus.done !== 1'b1 || bus.prime_count !== 5'd16 || bus.num !== 4'd15) begin
      errors++;
      $display("FAIL all_prime got done=%0b count=%0d num=%0d want 1 16 15",
               bus.done, bus.prime_count, bus.num);
    end
    drain();
    force_all = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.prime_ready = 1'b0;
    test_reset();
    test_free_run();
    test_backpressure();
    test_reset_mid_scan();
    test_start_ignored();
    test_restart_keeps_fifo();
    test_force_all();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/prime_scan.md
PRIME_SCAN -- requirements
Module: prime_scan

Interface
REQ-001 WIDTH, 4, bit width of scanned numbers; scan range is 0 to 2^WIDTH-1.
REQ-002 DEPTH, 4, number of entries in the output FIFO (power of two, >=2).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a scan.
REQ-006 num  output  WIDTH  candidate value driven to the external prime checker.
REQ-007 res  input  1  combinational checker result for num (1 = prime).
REQ-008 prime_out  output  WIDTH  FIFO head value.
REQ-009 prime_valid  output  1  FIFO non-empty.
REQ-010 prime_ready  input  1  consumer accepts prime_out.
REQ-011 prime_count  output  WIDTH+1  primes pushed in the current scan.
REQ-012 busy  output  1  high in SCAN.
REQ-013 done  output  1  high in DONE.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, SCAN and DONE.
REQ-015 IDLE->SCAN and DONE->SCAN SHALL occur on start=1; on entering SCAN, cnt SHALL be 0 and prime_count SHALL be 0.
REQ-016 start SHALL be ignored while in SCAN.
REQ-017 num SHALL equal the registered counter cnt in every state; cnt SHALL hold its value outside SCAN.
REQ-018 In SCAN, res SHALL be sampled in the same cycle that num=cnt is driven; the checker is combinational.
REQ-019 In SCAN with res=0, cnt SHALL increment with no push.
REQ-020 In SCAN with res=1 and FIFO not full: cnt SHALL be pushed, prime_count SHALL increment, and cnt SHALL increment.
REQ-021 In SCAN with res=1 and FIFO full: no push and no increment; cnt SHALL hold (stall) until a slot frees.
REQ-022 Full SHALL be evaluated before any same-cycle pop; a pop while full frees the slot for the next cycle only.
REQ-023 When cnt=2^WIDTH-1 is processed (not stalled): the FSM SHALL go to DONE and cnt SHALL hold at 2^WIDTH-1 (no wrap).
REQ-024 With no stalls, SCAN SHALL last exactly 2^WIDTH cycles.
REQ-025 A pop SHALL occur when prime_valid=1 and prime_ready=1; prime_ready with an empty FIFO SHALL have no effect.
REQ-026 Push and pop in the same cycle on a non-full, non-empty FIFO SHALL keep the occupancy unchanged.
REQ-027 Pops SHALL be accepted in every state, including IDLE and DONE.
REQ-028 Pointers SHALL wrap modulo DEPTH.
REQ-029 FIFO order SHALL be ascending scan order.
REQ-030 Restarting from DONE SHALL NOT flush the FIFO; entries from the prior scan SHALL remain ahead of new ones.
REQ-031 prime_count SHALL saturate at 2^(WIDTH+1)-1 and hold its value in DONE until the next start.

Reset
REQ-032 On rst=1 at a clock edge: state=IDLE, cnt=0, num=0, FIFO empty, prime_valid=0, prime_out=0, prime_count=0, busy=0, done=0.
REQ-033 rst SHALL take priority over start and over any push or pop in the same cycle.
REQ-034 rst asserted mid-SCAN SHALL abort the scan and discard FIFO contents.

Verification
REQ-035 Free-running consumer: rst, then start, prime_ready=1, golden checker -> popped sequence 2,3,5,7,11,13; prime_count=6; done at 16 cycles after start.
REQ-036 Backpressure: prime_ready=0 -> FIFO holds 2,3,5,7, stalls with num=11 and busy=1; raise prime_ready -> 11,13 follow; done; total 6 pops in order.
REQ-037 Full-plus-pop cycle: FIFO full and num=11 with a single pop pulse -> 11 is pushed the cycle after the pop, not during it.
REQ-038 Reset mid-scan: rst at num=6 -> next cycle IDLE, num=0, prime_valid=0, prime_count=0; a new start rescans from 0.
REQ-039 start pulses during SCAN -> no effect on cnt; restart from DONE with 2 unpopped entries -> old entries pop before the new 2.
REQ-040 Checker forced to res=1 for all values, WIDTH=4 -> prime_count=16, no wrap; done after all 16 pushes drain.
